// File: rtl/xor_session_ctrl.sv
// xor_session_ctrl: steers serial key/message bits to the deserializers,
// then sequences encryption and transmission with a timeout guard.
module xor_session_ctrl #(
    parameter int MSG_SIZE = 64,
    parameter int KEY_SIZE = 8,
    parameter int TIMEOUT  = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       iStart,
    input  logic       iAbort,
    input  logic       iSerial,
    input  logic       iBit_valid,
    input  logic       iEnc_done,
    input  logic       iTx_done,
    output logic       oData_bit,
    output logic       oKey_flag,
    output logic       oMsg_flag,
    output logic       oTx_start,
    output logic       oBusy,
    output logic       oDone,
    output logic       oError,
    output logic [2:0] oState
);
    localparam int CW = $clog2(MSG_SIZE) + 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_KEY  = 3'd1,
        S_MSG  = 3'd2,
        S_ENC  = 3'd3,
        S_TX   = 3'd4,
        S_DONE = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    state_t        r_state, w_next;
    logic [CW-1:0] r_bcnt, w_bcnt;
    logic [7:0]    r_tcnt, w_tcnt;
    logic          r_data, r_key, r_msg, r_tx, r_done, r_error;
    logic          w_key, w_msg, w_tx, w_done, w_error;
    logic          w_last_key, w_last_msg, w_tmo;

    assign w_last_key = r_bcnt == CW'(KEY_SIZE - 1);
    assign w_last_msg = r_bcnt == CW'(MSG_SIZE - 1);
    assign w_tmo      = r_tcnt == 8'(TIMEOUT - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_bcnt  <= '0;
            r_tcnt  <= '0;
        end else if (ena) begin
            r_state <= w_next;
            r_bcnt  <= w_bcnt;
            r_tcnt  <= w_tcnt;
        end
    end

    // Completion is checked before expiry so a done on the last cycle still proceeds.
    always_comb begin
        w_next = r_state;
        w_bcnt = r_bcnt;
        w_tcnt = r_tcnt;
        if (iAbort) begin
            w_next = S_IDLE;
            w_bcnt = '0;
            w_tcnt = '0;
        end else begin
            case (r_state)
                S_IDLE, S_ERR: if (iStart) begin
                    w_next = S_KEY;
                    w_bcnt = '0;
                end
                S_KEY: if (iBit_valid) begin
                    w_next = w_last_key ? S_MSG : S_KEY;
                    w_bcnt = w_last_key ? '0 : r_bcnt + 1'b1;
                end
                S_MSG: if (iBit_valid) begin
                    w_next = w_last_msg ? S_ENC : S_MSG;
                    w_bcnt = w_last_msg ? '0 : r_bcnt + 1'b1;
                    w_tcnt = '0;
                end
                S_ENC: if (iEnc_done) begin
                    w_next = S_TX;
                    w_tcnt = '0;
                end else if (w_tmo) begin
                    w_next = S_ERR;
                end else begin
                    w_tcnt = r_tcnt + 1'b1;
                end
                S_TX: if (iTx_done) begin
                    w_next = S_DONE;
                end else if (w_tmo) begin
                    w_next = S_ERR;
                end else begin
                    w_tcnt = r_tcnt + 1'b1;
                end
                S_DONE:  w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_key   = !iAbort && r_state == S_KEY && iBit_valid;
        w_msg   = !iAbort && r_state == S_MSG && iBit_valid;
        w_tx    = !iAbort && r_state == S_ENC && iEnc_done;
        w_done  = !iAbort && r_state == S_TX && iTx_done;
        w_error = (w_next == S_ERR) || (r_error && w_next != S_KEY);
    end

    // Pulses and flags drop while disabled so downstream never double-shifts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= 1'b0;
            r_key   <= 1'b0;
            r_msg   <= 1'b0;
            r_tx    <= 1'b0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
        end else if (ena) begin
            r_data  <= iSerial;
            r_key   <= w_key;
            r_msg   <= w_msg;
            r_tx    <= w_tx;
            r_done  <= w_done;
            r_error <= w_error;
        end else begin
            r_key   <= 1'b0;
            r_msg   <= 1'b0;
            r_tx    <= 1'b0;
            r_done  <= 1'b0;
        end
    end

    assign oData_bit = r_data;
    assign oKey_flag = r_key;
    assign oMsg_flag = r_msg;
    assign oTx_start = r_tx;
    assign oDone     = r_done;
    assign oError    = r_error;
    assign oState    = r_state;
    assign oBusy     = r_state inside {S_KEY, S_MSG, S_ENC, S_TX};
endmodule

// File: tb/tb_xor_session_ctrl.sv
// tb_xor_session_ctrl: directed scenario tests for the session sequencer
// (TIMEOUT=16, KEY_SIZE=8, MSG_SIZE=64).
module tb_xor_session_ctrl;
    logic       clk, rst_n, ena, iStart, iAbort, iSerial, iBit_valid, iEnc_done, iTx_done;
    logic       oData_bit, oKey_flag, oMsg_flag, oTx_start, oBusy, oDone, oError;
    logic [2:0] oState;
    int         tests, fails, kf, mf;
    logic [63:0] cap;
    logic [63:0] msg;

    xor_session_ctrl #(.MSG_SIZE(64), .KEY_SIZE(8), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .iStart(iStart), .iAbort(iAbort),
        .iSerial(iSerial), .iBit_valid(iBit_valid), .iEnc_done(iEnc_done), .iTx_done(iTx_done),
        .oData_bit(oData_bit), .oKey_flag(oKey_flag), .oMsg_flag(oMsg_flag), .oTx_start(oTx_start),
        .oBusy(oBusy), .oDone(oDone), .oError(oError), .oState(oState)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bits(input int n, input logic [63:0] pat, output int k, output int m, output logic [63:0] c);
        k = 0;
        m = 0;
        c = '0;
        for (int i = 0; i < n; i++) begin
            iSerial = pat[n-1-i];
            iBit_valid = 1'b1;
            step();
            k += int'(oKey_flag);
            m += int'(oMsg_flag);
            if (oKey_flag || oMsg_flag) c = {c[62:0], oData_bit};
        end
        iBit_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        tests++;
        if ({oData_bit, oKey_flag, oMsg_flag, oTx_start, oBusy, oDone, oError, oState} !== 10'd0) begin
            fails++;
            $display("FAIL reset_outputs got=%b exp=0", {oData_bit, oKey_flag, oMsg_flag, oTx_start, oBusy, oDone, oError, oState});
        end
        rst_n = 1'b1;
        step();
        tests++;
        if (oState !== 3'd0 || oBusy !== 1'b0) begin
            fails++;
            $display("FAIL reset_release got state=%0d busy=%b exp state=0 busy=0", oState, oBusy);
        end
    endtask

    task automatic test_nominal();
        iStart = 1'b1;
        step();
        iStart = 1'b0;
        tests++;
        if (oState !== 3'd1 || oBusy !== 1'b1) begin
            fails++;
            $display("FAIL nom_start got state=%0d busy=%b exp state=1 busy=1", oState, oBusy);
        end
        drive_bits(8, 64'hA5, kf, mf, cap);
        tests++;
        if (kf !== 8 || mf !== 0 || cap[7:0] !== 8'hA5 || oState !== 3'd2) begin
            fails++;
            $display("FAIL nom_key got kf=%0d mf=%0d key=%h state=%0d exp 8 0 a5 2", kf, mf, cap[7:0], oState);
        end
        drive_bits(64, msg, kf, mf, cap);
        tests++;
        if (kf !== 0 || mf !== 64 || cap !== msg || oState !== 3'd3) begin
            fails++;
            $display("FAIL nom_msg got kf=%0d mf=%0d msg=%h state=%0d exp 0 64 %h 3", kf, mf, cap, oState, msg);
        end
        repeat (4) step();
        tests++;
        if (oState !== 3'd3 || oTx_start !== 1'b0) begin
            fails++;
            $display("FAIL nom_enc_wait got state=%0d tx=%b exp state=3 tx=0", oState, oTx_start);
        end
        iEnc_done = 1'b1;
        step();
        iEnc_done = 1'b0;
        tests++;
        if (oState !== 3'd4 || oTx_start !== 1'b1) begin
            fails++;
            $display("FAIL nom_tx_start got state=%0d tx=%b exp state=4 tx=1", oState, oTx_start);
        end
        step();
        tests++;
        if (oState !== 3'd4 || oTx_start !== 1'b0) begin
            fails++;
            $display("FAIL nom_tx_pulse got state=%0d tx=%b exp state=4 tx=0", oState, oTx_start);
        end
        iTx_done = 1'b1;
        step();
        iTx_done = 1'b0;
        tests++;
        if (oState !== 3'd5 || oDone !== 1'b1 || oBusy !== 1'b0) begin
            fails++;
            $display("FAIL nom_done got state=%0d done=%b busy=%b exp 5 1 0", oState, oDone, oBusy);
        end
        step();
        tests++;
        if (oState !== 3'd0 || oDone !== 1'b0) begin
            fails++;
            $display("FAIL nom_idle got state=%0d done=%b exp 0 0", oState, oDone);
        end
    endtask

    task automatic test_gapped();
        int k = 0;
        iStart = 1'b1;
        step();
        iStart = 1'b0;
        for (int i = 0; i < 16; i++) begin
            iBit_valid = (i % 2) == 0;
            iSerial = i[1];
            step();
            k += int'(oKey_flag);
            if (i == 13) begin
                tests++;
                if (oState !== 3'd1 || oKey_flag !== 1'b0) begin
                    fails++;
                    $display("FAIL gap_hold got state=%0d flag=%b exp 1 0", oState, oKey_flag);
                end
            end
        end
        iBit_valid = 1'b0;
        tests++;
        if (k !== 8 || oState !== 3'd2 || oMsg_flag !== 1'b0) begin
            fails++;
            $display("FAIL gap_count got kf=%0d state=%0d mflag=%b exp 8 2 0", k, oState, oMsg_flag);
        end
        iAbort = 1'b1;
        step();
        iAbort = 1'b0;
    endtask

    task automatic test_timeout();
        iStart = 1'b1;
        step();
        iStart = 1'b0;
        drive_bits(8, 64'h3C, kf, mf, cap);
        drive_bits(64, msg, kf, mf, cap);
        repeat (15) step();
        tests++;
        if (oState !== 3'd3) begin
            fails++;
            $display("FAIL to_enc_early got state=%0d exp 3", oState);
        end
        step();
        tests++;
        if (oState !== 3'd6 || oError !== 1'b1 || oBusy !== 1'b0) begin
            fails++;
            $display("FAIL to_enc_err got state=%0d err=%b busy=%b exp 6 1 0", oState, oError, oBusy);
        end
        step();
        tests++;
        if (oState !== 3'd6 || oError !== 1'b1) begin
            fails++;
            $display("FAIL to_sticky got state=%0d err=%b exp 6 1", oState, oError);
        end
        iStart = 1'b1;
        step();
        iStart = 1'b0;
        tests++;
        if (oState !== 3'd1 || oError !== 1'b0) begin
            fails++;
            $display("FAIL to_restart got state=%0d err=%b exp 1 0", oState, oError);
        end
        drive_bits(8, 64'h3C, kf, mf, cap);
        drive_bits(64, msg, kf, mf, cap);
        repeat (15) step();
        iEnc_done = 1'b1;
        step();
        iEnc_done = 1'b0;
        tests++;
        if (oState !== 3'd4 || oTx_start !== 1'b1) begin
            fails++;
            $display("FAIL to_done_wins got state=%0d tx=%b exp 4 1", oState, oTx_start);
        end
        repeat (15) step();
        tests++;
        if (oState !== 3'd4) begin
            fails++;
            $display("FAIL to_tx_early got state=%0d exp 4", oState);
        end
        step();
        tests++;
        if (oState !== 3'd6 || oError !== 1'b1) begin
            fails++;
            $display("FAIL to_tx_err got state=%0d err=%b exp 6 1", oState, oError);
        end
        iAbort = 1'b1;
        step();
        iAbort = 1'b0;
        tests++;
        if (oState !== 3'd0 || oError !== 1'b1) begin
            fails++;
            $display("FAIL to_err_abort got state=%0d err=%b exp 0 1", oState, oError);
        end
    endtask

    task automatic test_abort();
        iStart = 1'b1;
        step();
        iStart = 1'b0;
        tests++;
        if (oError !== 1'b0 || oState !== 3'd1) begin
            fails++;
            $display("FAIL ab_start got state=%0d err=%b exp 1 0", oState, oError);
        end
        drive_bits(8, 64'h5A, kf, mf, cap);
        drive_bits(30, msg, kf, mf, cap);
        iAbort = 1'b1;
        iBit_valid = 1'b1;
        step();
        iAbort = 1'b0;
        iBit_valid = 1'b0;
        tests++;
        if (oState !== 3'd0 || oMsg_flag !== 1'b0 || oDone !== 1'b0) begin
            fails++;
            $display("FAIL ab_idle got state=%0d mflag=%b done=%b exp 0 0 0", oState, oMsg_flag, oDone);
        end
        iStart = 1'b1;
        step();
        iStart = 1'b0;
        drive_bits(8, 64'h5A, kf, mf, cap);
        tests++;
        if (kf !== 8 || oState !== 3'd2) begin
            fails++;
            $display("FAIL ab_rekey got kf=%0d state=%0d exp 8 2", kf, oState);
        end
        drive_bits(63, msg, kf, mf, cap);
        tests++;
        if (mf !== 63 || oState !== 3'd2) begin
            fails++;
            $display("FAIL ab_remsg got mf=%0d state=%0d exp 63 2", mf, oState);
        end
        drive_bits(1, msg, kf, mf, cap);
        tests++;
        if (mf !== 1 || oState !== 3'd3) begin
            fails++;
            $display("FAIL ab_last got mf=%0d state=%0d exp 1 3", mf, oState);
        end
        iAbort = 1'b1;
        step();
        iAbort = 1'b0;
    endtask

    task automatic test_busy_ena();
        int k = 0;
        iStart = 1'b1;
        step();
        iStart = 1'b0;
        drive_bits(4, 64'hF, kf, mf, cap);
        k += kf;
        ena = 1'b0;
        iBit_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if (oKey_flag !== 1'b0 || oState !== 3'd1) begin
                fails++;
                $display("FAIL ena_freeze got flag=%b state=%0d exp 0 1", oKey_flag, oState);
            end
        end
        ena = 1'b1;
        iBit_valid = 1'b0;
        drive_bits(3, 64'h0, kf, mf, cap);
        k += kf;
        tests++;
        if (oState !== 3'd1) begin
            fails++;
            $display("FAIL ena_resume got state=%0d exp 1", oState);
        end
        drive_bits(1, 64'h0, kf, mf, cap);
        k += kf;
        tests++;
        if (k !== 8 || oState !== 3'd2) begin
            fails++;
            $display("FAIL ena_total got kf=%0d state=%0d exp 8 2", k, oState);
        end
        drive_bits(10, msg, kf, mf, cap);
        iStart = 1'b1;
        drive_bits(1, msg, kf, mf, cap);
        iStart = 1'b0;
        tests++;
        if (oState !== 3'd2 || oMsg_flag !== 1'b1) begin
            fails++;
            $display("FAIL busy_start got state=%0d mflag=%b exp 2 1", oState, oMsg_flag);
        end
        drive_bits(52, msg, kf, mf, cap);
        tests++;
        if (oState !== 3'd2) begin
            fails++;
            $display("FAIL busy_cnt got state=%0d exp 2", oState);
        end
        drive_bits(1, msg, kf, mf, cap);
        tests++;
        if (oState !== 3'd3) begin
            fails++;
            $display("FAIL busy_end got state=%0d exp 3", oState);
        end
        iAbort = 1'b1;
        step();
        iAbort = 1'b0;
    endtask

    task automatic test_async_reset();
        iStart = 1'b1;
        step();
        iStart = 1'b0;
        drive_bits(8, 64'hA5, kf, mf, cap);
        drive_bits(64, msg, kf, mf, cap);
        iEnc_done = 1'b1;
        step();
        iEnc_done = 1'b0;
        tests++;
        if (oState !== 3'd4) begin
            fails++;
            $display("FAIL ar_tx got state=%0d exp 4", oState);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({oData_bit, oKey_flag, oMsg_flag, oTx_start, oBusy, oDone, oError, oState} !== 10'd0) begin
            fails++;
            $display("FAIL ar_immediate got=%b exp=0", {oData_bit, oKey_flag, oMsg_flag, oTx_start, oBusy, oDone, oError, oState});
        end
        #1;
        rst_n = 1'b1;
        iTx_done = 1'b1;
        step();
        iTx_done = 1'b0;
        tests++;
        if (oState !== 3'd0 || oDone !== 1'b0) begin
            fails++;
            $display("FAIL ar_after got state=%0d done=%b exp 0 0", oState, oDone);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        msg = 64'hDEADBEEF01234567;
        rst_n = 1'b0;
        ena = 1'b1;
        iStart = 1'b0;
        iAbort = 1'b0;
        iSerial = 1'b0;
        iBit_valid = 1'b0;
        iEnc_done = 1'b0;
        iTx_done = 1'b0;
        test_reset();
        test_nominal();
        test_gapped();
        test_timeout();
        test_abort();
        test_busy_ena();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
